// File: rtl/wired_utils_pkg.sv
// wired_utils_pkg: shared width helpers and wrap-increment for wired pipeline blocks
package wired_utils_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic logic [31:0] wrap_inc(input logic [31:0] v, input int limit);
        return (v == 32'(limit - 1)) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/wired_wrap_ptr.sv
// wired_wrap_ptr: pointer register with enable, synchronous clear and wrap at LIMIT-1
module wired_wrap_ptr
    import wired_utils_pkg::*;
#(
    parameter int LIMIT = 2,
    parameter int W     = ptr_width(LIMIT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q, ptr_d;

    // clear wins over advance; advance wraps from LIMIT-1 back to 0
    always_comb ptr_d = clr_i ? '0 : en_i ? W'(wrap_inc(32'(ptr_q), LIMIT)) : ptr_q;

    // pointer state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/wired_pipebuf.sv
// wired_pipebuf: elastic valid/ready buffer with a DEPTH-entry circular store, flush and occupancy
module wired_pipebuf
    import wired_utils_pkg::*;
#(
    parameter type T         = logic [31:0],
    parameter int  DEPTH     = 2,
    parameter bit  CUT_READY = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        inp_valid_i,
    output logic                        inp_ready_o,
    input  logic [$bits(T)-1:0]         inp_i,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [$bits(T)-1:0]         oup_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int CW = cnt_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $fatal(1, "wired_pipebuf: DEPTH must be at least 1");
    end

    logic [$bits(T)-1:0] mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                full, push, pop;

    assign full        = (cnt_q == CW'(DEPTH));
    assign inp_ready_o = CUT_READY ? !full : (!full || oup_ready_i);
    assign oup_valid_o = (cnt_q != '0);
    assign oup_o       = mem_q[rd_ptr];
    assign count_o     = cnt_q;
    assign push        = inp_valid_i && inp_ready_o;
    assign pop         = oup_valid_o && oup_ready_i;

    // occupancy: flush empties; a simultaneous push and pop leaves it unchanged
    always_comb cnt_d = flush_i ? '0 : (push && !pop) ? cnt_q + 1'b1 : (pop && !push) ? cnt_q - 1'b1 : cnt_q;

    // occupancy register, emptied asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // payload store is never reset; a write during flush is harmless since pointers restart at 0
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr] <= inp_i;
    end

    wired_wrap_ptr #(.LIMIT(DEPTH), .W(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush_i),
        .en_i  (push),
        .ptr_o (wr_ptr)
    );

    wired_wrap_ptr #(.LIMIT(DEPTH), .W(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush_i),
        .en_i  (pop),
        .ptr_o (rd_ptr)
    );

endmodule
